// File: rtl/pipe_issue_pkg.sv
// Shared field widths, instruction layout, FSM states and func codes for the
// pipeline issue front-end.
package pipe_issue_pkg;
    localparam int REG_W   = 4;
    localparam int FUNC_W  = 4;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 24;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rs1;
    } instr_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_t;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    typedef enum logic [FUNC_W-1:0] {
        F_ADD = 4'd0, F_SUB = 4'd1, F_MUL = 4'd2,
        F_SEL = 4'd3, F_AND = 4'd4, F_XOR = 4'd5
    } func_e;
endpackage

// File: rtl/pipe_issue_unit_fifo.sv
// Synchronous DEPTH x W FIFO with explicit occupancy count and head peek.
module issue_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign head = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pipe_issue_unit.sv
// Issue front-end: FIFO-buffered instructions issued one per clock, with a
// destination scoreboard that inserts bubbles on read-after-write hazards.
module pipe_issue_unit
    import pipe_issue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int HAZ_WINDOW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic                   flush,
    output logic                   issue_valid,
    output logic [REG_W-1:0]       issue_rs1,
    output logic [REG_W-1:0]       issue_rs2,
    output logic [REG_W-1:0]       issue_rd,
    output logic [FUNC_W-1:0]      issue_func,
    output logic [ADDR_W-1:0]      issue_addr,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;

    instr_t head;
    state_t state;
    sb_t    sb [HAZ_WINDOW];
    logic   push, issue, raw, hazard, nonempty;

    assign in_ready = count < CW'(DEPTH);
    assign nonempty = count != '0;
    assign push     = in_valid && in_ready && !flush;

    issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .pop   (issue),
        .din   (in_instr),
        .head  (head),
        .count (count)
    );

    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++)
            if (sb[i].v && (sb[i].rd == head.rs1 || sb[i].rd == head.rs2))
                raw = 1'b1;
    end

    // Issue is not gated by state so an empty unit falls through in one cycle.
    assign hazard = nonempty && raw;
    assign issue  = !flush && nonempty && !raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            issue_rs1   <= '0;
            issue_rs2   <= '0;
            issue_rd    <= '0;
            issue_func  <= '0;
            issue_addr  <= '0;
            for (int i = 0; i < HAZ_WINDOW; i++) sb[i] <= '0;
        end else if (flush) begin
            state       <= IDLE;
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            for (int i = 0; i < HAZ_WINDOW; i++) sb[i] <= '0;
        end else begin
            issue_valid <= issue;
            stall       <= hazard;
            if (issue) begin
                issue_rs1  <= head.rs1;
                issue_rs2  <= head.rs2;
                issue_rd   <= head.rd;
                issue_func <= head.func;
                issue_addr <= head.addr;
            end
            sb[0] <= '{v: issue, rd: head.rd};
            for (int i = 1; i < HAZ_WINDOW; i++) sb[i] <= sb[i-1];
            case (state)
                IDLE:    if (nonempty) state <= hazard ? STALL : RUN;
                RUN:     if (hazard) state <= STALL;
                         else if (issue && count == CW'(1) && !push) state <= IDLE;
                STALL:   if (!hazard) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pipe_issue_unit.md
# pipe_issue_unit

Instruction issue front-end for the 4-stage `pipeline_4` datapath. It buffers encoded instructions in a small FIFO and issues at most one per clock to the pipeline's `rs1/rs2/rd/func/addr` inputs. A destination scoreboard inserts bubbles on read-after-write hazards, so a dependent instruction never reads a register that an in-flight instruction has not yet written back.

## Interface
- `DEPTH`, 8: FIFO entries. Power of two, 2..16.
- `HAZ_WINDOW`, 3: cycles after issue during which a destination register is still in flight.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  producer offers `in_instr`.
- `in_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `in_instr`  in  24  packed `{addr[7:0], func[3:0], rd[3:0], rs2[3:0], rs1[3:0]}`, rs1 in the LSBs.
- `flush`  in  1  synchronous discard of the queue and scoreboard.
- `issue_valid`  out  1  registered; high for exactly one cycle per issued instruction.
- `issue_rs1`, `issue_rs2`, `issue_rd`, `issue_func`  out  4 each  registered instruction fields.
- `issue_addr`  out  8  registered memory address field.
- `stall`  out  1  registered; high in a cycle where the head was held for a hazard.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` writes `in_instr` at the tail. No push occurs when full, even if a pop happens in the same cycle.
- Scoreboard: `sb[0..HAZ_WINDOW-1]` of `{v, rd}`.
  - Every clock: `sb[0] <= {issued, head.rd}` and `sb[i] <= sb[i-1]`.
  - A bubble inserts `v=0`.
- Hazard: head valid, and `head.rs1` or `head.rs2` equals `sb[i].rd` for any `sb[i].v`. All 16 registers are tracked, including r0.
- FSM:
  - IDLE: FIFO empty → RUN on a non-empty FIFO.
  - RUN: issue the head when there is no hazard. Go to STALL on a hazard, or to IDLE when the FIFO drains.
  - STALL: hold the head with `issue_valid=0` and `stall=1`. Go to RUN once the hazard clears, issuing on that edge.
- Issue pops the head and loads the `issue_*` registers.
- When not issuing:
  - `issue_valid=0`.
  - The field outputs hold their last values.
- `flush` has priority over push, pop and issue:
  - Empties the FIFO (`count=0`) and clears all `sb[i].v`.
  - Forces IDLE with `issue_valid=0` and `stall=0` on the next cycle.
  - A push in the same cycle is dropped.
- Reset: all outputs 0 (`in_ready=1`, `count=0`), FIFO pointers 0, scoreboard invalid, FSM in IDLE. Asynchronous assertion mid-stream drops everything in flight.
- Pointers wrap modulo DEPTH. `count` is kept separately so that full and empty are unambiguous.

## Timing
- Fall-through latency: an instruction pushed at edge t into an empty, hazard-free unit has `issue_valid=1` after edge t+1.
- Throughput: one issue per cycle while independent instructions are queued.
- Dependent pair: A issued at edge t, B reading A.rd is the new head. B issues at edge t+1+HAZ_WINDOW, i.e. edge t+4 by default, with `stall=1` for the 3 intervening cycles.
- A dependence on an older instruction stalls only for the remaining scoreboard lifetime of that entry.
- A simultaneous push and pop with `0<count<DEPTH` leaves `count` unchanged.
- `in_ready` is combinational from `count`; it does not look ahead at a pop in the same cycle.

## Structure
- Package `pipe_issue_pkg` holds:
  - the field widths (`REG_W=4`, `FUNC_W=4`, `ADDR_W=8`, `INSTR_W=24`);
  - the packed instruction struct;
  - the FSM state enum `{IDLE, RUN, STALL}`;
  - the func codes 0..5 (ADD, SUB, MUL, SEL, AND, XOR) used by the pipeline.
- Sub-module `issue_fifo`: parameterised DEPTH×INSTR_W synchronous FIFO with count, head peek, push and pop. The FSM and scoreboard stay in the top module.

## Test plan
- Independent stream: push `{125,0,10,3,5}`, `{126,1,11,2,3}`, `{127,2,12,1,4}` back-to-back → issue on 3 consecutive cycles starting one cycle after the first push, fields in order, `stall` never set.
- RAW stall: push rd=10 then rs1=10, rd=11 → second instruction issues 4 edges after the first, with `stall=1` for exactly 3 cycles.
- Fill/overflow: hold the head with a hazard and push 9 instructions with DEPTH=8 → `in_ready=0` at `count=8`, the 9th is not accepted, and all 8 issue in order afterwards.
- Flush mid-stall: 5 queued, head stalled, pulse `flush` together with `in_valid` → next cycle `count=0`, `issue_valid=0`, `stall=0`; a subsequent rs1=10 instruction issues without a stall.
- Reset mid-operation: drop `rst_n` asynchronously between edges with 4 queued → outputs 0 and `count=0` immediately; after release the first new push issues with 1-cycle latency.
- Wrap-around: 20 independent pushes with interleaved pops → issued sequence equals pushed sequence, and `count` never exceeds 8.
